// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Multi-channel button debouncer and edge detector. Each raw
//               input is double-flop synchronised, optionally inverted, then
//               filtered by a four-state FSM. A change is accepted only after
//               the sample stays stable for DEBOUNCE_CYCLES clocks. Each
//               channel presents a clean level plus one-cycle press and
//               release strobes.
//
// Optional    : `define BTN_AUTOREPEAT_EN builds an auto-repeat generator.
//               While a button is held, press_o re-fires REPEAT_DELAY cycles
//               after the accepted press, then every REPEAT_RATE cycles.
//               Without the macro, repeat_o is tied to 0.
//
// Ports       : clk        system clock
//               reset      asynchronous active-low reset
//               btn_i      raw button pins (asynchronous to clk)
//               level_o    debounced pressed level (1 = pressed)
//               press_o    one-cycle strobe on accepted press / repeat
//               release_o  one-cycle strobe on accepted release
//               repeat_o   high while the channel is auto-repeating
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW_IN   = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = $clog2(
        (DEBOUNCE_CYCLES > REPEAT_DELAY)
            ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? DEBOUNCE_CYCLES : REPEAT_RATE)
            : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE)) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] press_o,
    output logic [NUM_CH-1:0] release_o,
    output logic [NUM_CH-1:0] repeat_o
);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_ZERO    = '0;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Synchroniser flops reset to the "not pressed" pin level so that
    // reset release never looks like an edge.
    localparam logic             c_IDLE    = (ACTIVE_LOW_IN != 0);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_RPT_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RPT_RATE_LAST = CNT_W'(REPEAT_RATE - 1);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       r_sync;
        logic             w_s;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             w_rel_accept;
        logic             r_level;
        logic             r_press;
        logic             r_release;

        // r_sync[1] is the synchronised pin; invert for active-low boards.
        assign w_s       = r_sync[1] ^ c_IDLE;
        assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_ONE);

        // Release acceptance is computed once so the repeat generator can
        // yield to it: press and release never strobe in the same cycle.
        assign w_rel_accept = (r_state == S_RELEASE_PEND) && !w_s && (r_cnt == c_DB_LAST);

`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] r_rcnt;
        logic             r_rep;
        logic             w_held;
        logic             w_rpt_fire;

        // The repeat timer keeps running through RELEASE_PEND; a release
        // that is rejected as a glitch does not restart repeat timing.
        assign w_held     = (r_state == S_PRESSED) || (r_state == S_RELEASE_PEND);
        assign w_rpt_fire = r_rep ? (r_rcnt == c_RPT_RATE_LAST) : (r_rcnt == c_RPT_DLY_LAST);
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync    <= {2{c_IDLE}};
                r_state   <= S_RELEASED;
                r_cnt     <= c_ZERO;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                r_rcnt    <= c_ZERO;
                r_rep     <= 1'b0;
`endif
            end else begin
                r_sync    <= {r_sync[0], btn_i[i]};
                r_press   <= 1'b0;
                r_release <= 1'b0;

                case (r_state)
                    S_RELEASED: begin
                        if (w_s) begin
                            r_state <= S_PRESS_PEND;
                            r_cnt   <= c_ONE;
                        end else begin
                            r_cnt   <= c_ZERO;
                        end
                    end
                    S_PRESS_PEND: begin
                        if (!w_s) begin
                            r_state <= S_RELEASED;
                            r_cnt   <= c_ZERO;
                        end else if (r_cnt == c_DB_LAST) begin
                            r_state <= S_PRESSED;
                            r_cnt   <= c_ZERO;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            r_rcnt  <= c_ZERO;
                            r_rep   <= 1'b0;
`endif
                        end else begin
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                    S_PRESSED: begin
                        if (!w_s) begin
                            r_state <= S_RELEASE_PEND;
                            r_cnt   <= c_ONE;
                        end else begin
                            r_cnt   <= c_ZERO;
                        end
                    end
                    S_RELEASE_PEND: begin
                        if (w_s) begin
                            r_state   <= S_PRESSED;
                            r_cnt     <= c_ZERO;
                        end else if (w_rel_accept) begin
                            r_state   <= S_RELEASED;
                            r_cnt     <= c_ZERO;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            r_rcnt    <= c_ZERO;
                            r_rep     <= 1'b0;
`endif
                        end else begin
                            r_cnt     <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_RELEASED;
                        r_cnt   <= c_ZERO;
                    end
                endcase

`ifdef BTN_AUTOREPEAT_EN
                if (w_held && !w_rel_accept) begin
                    if (w_rpt_fire) begin
                        r_press <= 1'b1;
                        r_rep   <= 1'b1;
                        r_rcnt  <= c_ZERO;
                    end else if (r_rcnt != c_CNT_MAX) begin
                        r_rcnt  <= r_rcnt + c_ONE;
                    end
                end
`endif
            end
        end

        assign level_o[i]   = r_level;
        assign press_o[i]   = r_press;
        assign release_o[i] = r_release;
`ifdef BTN_AUTOREPEAT_EN
        assign repeat_o[i]  = r_rep;
`else
        assign repeat_o[i]  = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel, parametrised button debouncer and edge detector for the front-panel inputs of the digital clock. Each of NUM_CH raw mechanical inputs is synchronised, filtered until stable for DEBOUNCE_CYCLES consecutive clocks, and presented as a clean level plus single-cycle press and release strobes. An optional auto-repeat generator re-fires the press strobe while a button is held, for fast time-setting. It sits between the board pins and the mode/set control FSM.

## Interface
- NUM_CH, 4, number of independent button channels
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (>= 2)
- ACTIVE_LOW_IN, 0, 1 = raw input is pressed when 0 (inverted after sync)
- REPEAT_DELAY, 50000000, hold cycles after the accepted press before the first repeat strobe
- REPEAT_RATE, 10000000, cycles between subsequent repeat strobes
- CNT_W, $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE, plus 1; counter width
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_i  input  NUM_CH  raw button pins, asynchronous to clk
- level_o  output  NUM_CH  debounced pressed level (1 = pressed)
- press_o  output  NUM_CH  one-cycle strobe on accepted press (and on each repeat when enabled)
- release_o  output  NUM_CH  one-cycle strobe on accepted release
- repeat_o  output  NUM_CH  high while the channel is in the repeating phase

## Operation
- Per channel: 2-FF synchroniser, then optional inversion (ACTIVE_LOW_IN) giving sample s.
- Per-channel FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
- RELEASED: s=1 -> PRESS_PEND, counter = 1; else counter held at 0.
- PRESS_PEND: s=0 -> RELEASED, counter = 0 (glitch rejected). s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED, level_o <= 1, press_o pulses, counter = 0. Otherwise counter increments.
- PRESSED: s=0 -> RELEASE_PEND, counter = 1. Release filtering is symmetric to press filtering.
- RELEASE_PEND: s=1 -> PRESSED (repeat timing is not restarted). Count reaching DEBOUNCE_CYCLES-1 -> RELEASED, level_o <= 0, release_o pulses, repeat_o <= 0.
- Channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.
- Counters saturate and never wrap. CNT_W must cover all three count limits.

## Timing
- Reset (reset=0, asynchronous): all FSMs go to RELEASED. Counters, synchroniser flops (inactive value), level_o, press_o, release_o and repeat_o all go to 0.
- Reset asserted mid-debounce or mid-repeat aborts immediately with no strobe. After reset is deasserted, a button that is already held is accepted as a new press after the full latency.
- Latency: a clean edge on btn_i first captured at clock edge k gives level_o/press_o (or release_o) asserted after edge k+1+DEBOUNCE_CYCLES, i.e. 2 sync cycles plus DEBOUNCE_CYCLES-1 in the pend state.
- press_o and release_o are registered and exactly one cycle wide. They never assert in the same cycle on the same channel.
- Any bounce shorter than DEBOUNCE_CYCLES cycles produces no change in the outputs.

## Configuration
- BTN_AUTOREPEAT_EN defined: a per-channel repeat counter runs in PRESSED and RELEASE_PEND.
  - REPEAT_DELAY cycles after the accepted press, press_o pulses and repeat_o goes to 1.
  - After that, press_o pulses every REPEAT_RATE cycles until the release is accepted.
- BTN_AUTOREPEAT_EN undefined: no repeat logic is built. repeat_o is tied to 0, press_o fires once per accepted press, and REPEAT_DELAY/REPEAT_RATE are ignored.

## Test plan
- NUM_CH=2, DEBOUNCE_CYCLES=8: btn_i[0] 0->1 clean at edge 10 -> level_o[0]=1 and a single press_o[0] pulse after edge 19; channel 1 stays quiet.
- Bounce: btn_i[0] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one press_o, 9 cycles after the final rising edge; no release_o.
- Release: from the pressed state, drive btn_i[0]=0 for 7 cycles then 1 -> no release_o. Then 0 held -> release_o pulses 9 cycles later and level_o=0.
- Simultaneous: both channels pressed on the same edge -> press_o=2'b11 in one cycle. ACTIVE_LOW_IN=1 with pins driven low gives the same result.
- Reset at cycle 5 of PRESS_PEND with the button held -> all outputs 0. After reset is released, press_o appears 9 cycles later.
- With BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5, hold for 40 cycles after acceptance -> press_o at +0, +20, +25, +30, +35, +40; repeat_o high from +20 until the release is accepted.
